// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes, functs,
// ALU control codes and datapath mux selects.
package mips_ctrl_pkg;

   typedef logic [3:0] state_t;

   localparam state_t FETCH   = 4'd0;
   localparam state_t DECODE  = 4'd1;
   localparam state_t MEMADR  = 4'd2;
   localparam state_t MEMRD   = 4'd3;
   localparam state_t MEMWB   = 4'd4;
   localparam state_t MEMWR   = 4'd5;
   localparam state_t RTYPEEX = 4'd6;
   localparam state_t RTYPEWB = 4'd7;
   localparam state_t BEQEX   = 4'd8;
   localparam state_t ADDIEX  = 4'd9;
   localparam state_t ADDIWB  = 4'd10;
   localparam state_t JEX     = 4'd11;
   localparam state_t ORIEX   = 4'd12;
   localparam state_t ORIWB   = 4'd13;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   // aluop tells the decoder whether to force an operation or look at funct
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps (aluop, funct) to the 3-bit ALU control code; funct_valid_o drops for
// R-type functs the ALU does not implement.
module mips_alu_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [1:0] aluop_i,
   input  logic [5:0] funct_i,
   output logic [2:0] alucontrol_o,
   output logic       funct_valid_o
);

   always_comb begin
      alucontrol_o  = ALU_ADD;
      funct_valid_o = 1'b1;
      unique case (aluop_i)
         ALUOP_ADD: alucontrol_o = ALU_ADD;
         ALUOP_SUB: alucontrol_o = ALU_SUB;
         ALUOP_OR:  alucontrol_o = ALU_OR;
         ALUOP_FUNCT: begin
            case (funct_i)
               FN_ADD:  alucontrol_o = ALU_ADD;
               FN_SUB:  alucontrol_o = ALU_SUB;
               FN_AND:  alucontrol_o = ALU_AND;
               FN_OR:   alucontrol_o = ALU_OR;
               FN_SLT:  alucontrol_o = ALU_SLT;
               default: funct_valid_o = 1'b0;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath, with embedded ALU decoder.
// Define MIPS_CTRL_ORI_EN to add ori support and the zeroext output.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol
`ifdef MIPS_CTRL_ORI_EN
   ,
   output logic       zeroext
`endif
);

   state_t     state_q, state_d;
   logic       funct_ok_q, funct_ok_d;
   logic       pcwrite_c, branch_c, memwrite_c, irwrite_c, regwrite_c;
   logic       alusrca_c, iord_c, memtoreg_c, regdst_c, zeroext_c;
   logic [1:0] alusrcb_c, pcsrc_c, aluop_c;
   logic [2:0] alucontrol_c;
   logic       funct_valid;

   mips_alu_decoder u_alu_decoder (
      .aluop_i       (aluop_c),
      .funct_i       (funct),
      .alucontrol_o  (alucontrol_c),
      .funct_valid_o (funct_valid)
   );

   always_comb begin
      state_d    = FETCH;
      funct_ok_d = funct_ok_q;
      pcwrite_c  = 1'b0;
      branch_c   = 1'b0;
      memwrite_c = 1'b0;
      irwrite_c  = 1'b0;
      regwrite_c = 1'b0;
      alusrca_c  = 1'b0;
      iord_c     = 1'b0;
      memtoreg_c = 1'b0;
      regdst_c   = 1'b0;
      zeroext_c  = 1'b0;
      alusrcb_c  = SRCB_B;
      pcsrc_c    = PC_ALU;
      aluop_c    = ALUOP_ADD;
      case (state_q)
         FETCH: begin
            irwrite_c = 1'b1;
            pcwrite_c = 1'b1;
            alusrcb_c = SRCB_FOUR;
            state_d   = DECODE;
         end
         DECODE: begin
            alusrcb_c = SRCB_IMMSH;
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = RTYPEEX;
               OP_BEQ:       state_d = BEQEX;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JEX;
`ifdef MIPS_CTRL_ORI_EN
               OP_ORI:       state_d = ORIEX;
`endif
               default:      state_d = FETCH;
            endcase
         end
         MEMADR: begin
            alusrca_c = 1'b1;
            alusrcb_c = SRCB_IMM;
            state_d   = (op == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            iord_c  = 1'b1;
            state_d = MEMWB;
         end
         MEMWB: begin
            memtoreg_c = 1'b1;
            regwrite_c = 1'b1;
         end
         MEMWR: begin
            iord_c     = 1'b1;
            memwrite_c = 1'b1;
         end
         RTYPEEX: begin
            alusrca_c  = 1'b1;
            aluop_c    = ALUOP_FUNCT;
            funct_ok_d = funct_valid;
            state_d    = RTYPEWB;
         end
         RTYPEWB: begin
            // An unimplemented funct must not corrupt the register file
            regdst_c   = 1'b1;
            regwrite_c = funct_ok_q;
         end
         BEQEX: begin
            alusrca_c = 1'b1;
            aluop_c   = ALUOP_SUB;
            pcsrc_c   = PC_ALUOUT;
            branch_c  = 1'b1;
         end
         ADDIEX: begin
            alusrca_c = 1'b1;
            alusrcb_c = SRCB_IMM;
            state_d   = ADDIWB;
         end
         ADDIWB: regwrite_c = 1'b1;
         JEX: begin
            pcsrc_c   = PC_JUMP;
            pcwrite_c = 1'b1;
         end
`ifdef MIPS_CTRL_ORI_EN
         ORIEX: begin
            alusrca_c = 1'b1;
            alusrcb_c = SRCB_IMM;
            zeroext_c = 1'b1;
            aluop_c   = ALUOP_OR;
            state_d   = ORIWB;
         end
         ORIWB: regwrite_c = 1'b1;
`endif
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= RESET_STATE;
         funct_ok_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         funct_ok_q <= funct_ok_d;
      end
   end

   // Outputs are gated so the datapath sees no strobes while reset is held
   always_comb begin
      pcen       = reset_n & (pcwrite_c | (branch_c & zero));
      memwrite   = reset_n & memwrite_c;
      irwrite    = reset_n & irwrite_c;
      regwrite   = reset_n & regwrite_c;
      alusrca    = reset_n & alusrca_c;
      alusrcb    = reset_n ? alusrcb_c : 2'b00;
      iord       = reset_n & iord_c;
      memtoreg   = reset_n & memtoreg_c;
      regdst     = reset_n & regdst_c;
      pcsrc      = reset_n ? pcsrc_c : 2'b00;
      alucontrol = reset_n ? alucontrol_c : 3'b000;
   end

`ifdef MIPS_CTRL_ORI_EN
   assign zeroext = reset_n & zeroext_c;
`else
   logic unused_zeroext;
   assign unused_zeroext = zeroext_c;
`endif

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Control unit for the multicycle MIPS datapath. It sits directly upstream of the ALU. A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback. An embedded ALU decoder drives the 3-bit alucontrol code consumed by the ALU. It also takes the ALU zero flag back to form the PC enable for beq.

Parameters:
- RESET_STATE, 4'd0 (FETCH): state entered on reset. Fixed; exists for bench visibility only.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag
- pcen  out  1  PC register enable
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regwrite  out  1  register file write
- alusrca  out  1  0 = PC, 1 = register A
- alusrcb  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- iord  out  1  0 = PC address, 1 = ALUOut address
- memtoreg  out  1  0 = ALUOut, 1 = memory data
- regdst  out  1  0 = rt, 1 = rd
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt

Behaviour:
- Reset and output gating
  - The state register resets asynchronously to FETCH.
  - While reset_n = 0, every output is forced to 0, independent of state.
  - Reset is honoured mid-instruction: on release, execution resumes at FETCH.
- Default outputs: every output is 0 (alucontrol = 000) in any state unless listed below.
- Per-state outputs:
  - FETCH: irwrite = 1, pcwrite = 1, alusrcb = 01, add. Go to DECODE.
  - DECODE: alusrcb = 11, add (precomputes branch target). Next state by op:
    - lw/sw (100011/101011) → MEMADR
    - R-type (000000) → RTYPEEX
    - beq (000100) → BEQEX
    - addi (001000) → ADDIEX
    - j (000010) → JEX
    - any other op → FETCH (treated as NOP, no architectural write)
  - MEMADR: alusrca = 1, alusrcb = 10, add. lw → MEMRD; sw → MEMWR.
  - MEMRD: iord = 1. Go to MEMWB.
  - MEMWB: memtoreg = 1, regwrite = 1. Go to FETCH.
  - MEMWR: iord = 1, memwrite = 1. Go to FETCH.
  - RTYPEEX: alusrca = 1, alusrcb = 00, alucontrol from funct. Go to RTYPEWB.
  - RTYPEWB: regdst = 1, regwrite = 1. Go to FETCH.
  - BEQEX: alusrca = 1, sub, pcsrc = 01, branch = 1. Go to FETCH.
  - ADDIEX: alusrca = 1, alusrcb = 10, add. Go to ADDIWB.
  - ADDIWB: regwrite = 1. Go to FETCH.
  - JEX: pcsrc = 10, pcwrite = 1. Go to FETCH.
- pcen = pcwrite | (branch & zero). This is combinational; zero is sampled in the same BEQEX cycle.
- ALU decode in RTYPEEX:
  - funct 100000 → 000, 100010 → 001, 100100 → 010, 100101 → 011, 101010 → 100.
  - Any other funct → 000, and regwrite is suppressed in the following RTYPEWB.
- Cycle counts, FETCH to return to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unsupported op 2.
- Encoded states never reached by the transitions above go to FETCH.

Optional Feature:
- Macro: MIPS_CTRL_ORI_EN.
- Defined:
  - Adds output zeroext (1 bit): 1 = zero-extend immediate.
  - Adds states ORIEX (alusrca = 1, alusrcb = 10, zeroext = 1, or) and ORIWB (regwrite = 1).
  - DECODE routes op 001101 → ORIEX; ORIEX → ORIWB → FETCH.
- Undefined: no zeroext port; op 001101 is unsupported and goes DECODE → FETCH.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum (4-bit)
  - opcode constants
  - funct constants
  - alucontrol constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT)
  - alusrcb and pcsrc select constants
- One sub-module, mips_alu_decoder: combinational mapping of (aluop[1:0], funct) → alucontrol plus a funct_valid flag. The FSM instantiates it.

Test Plan:
- Hold reset_n = 0 for 3 cycles → all outputs 0; release → irwrite = 1, pcen = 1, alusrcb = 01 in the first cycle.
- lw (op 100011) → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite = 1 and memtoreg = 1 only in cycle 5; back to FETCH in cycle 6.
- R-type with funct 101010 → alucontrol = 100 in RTYPEEX, regdst = 1 and regwrite = 1 next cycle; repeat with funct 111111 → alucontrol = 000, regwrite stays 0.
- beq with zero = 1 → pcen = 1, pcsrc = 01, alucontrol = 001 in BEQEX; with zero = 0 → pcen = 0 and no state stall.
- Unsupported op 111111 → FETCH, DECODE, FETCH with no regwrite or memwrite; reset asserted during MEMRD → outputs 0 immediately, restart at FETCH.
- With MIPS_CTRL_ORI_EN, op 001101 → zeroext = 1 and alucontrol = 011 in ORIEX, regwrite = 1 in ORIWB.
